// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception/interrupt arbiter. Forwards pending CP0 writes,
// picks the highest-priority event, redirects the PC, then sequences flush and stall.
module except_ctrl #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter logic [31:0] EXC_OFFSET  = 32'h180,
   parameter logic [31:0] INT_OFFSET  = 32'h200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic        syscall_i,
   input  logic        inst_inval_i,
   input  logic        trap_i,
   input  logic        overflow_i,
   input  logic        eret_i,
   input  logic [31:0] mem_inst_addr_i,
   input  logic        mem_in_delayslot_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic [31:0] ebase_i,
   input  logic        cp0_we_i,
   input  logic [4:0]  cp0_waddr_i,
   input  logic [31:0] cp0_wdata_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        stall_req_o
);

   typedef enum logic [1:0] {IDLE, FLUSH, HOLD} state_t;

   localparam logic [2:0] HOLD_LD = 3'(HOLD_CYCLES);

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic [31:0] fwd_status, fwd_cause, fwd_epc;
   logic        int_req;
   logic [31:0] code, vec_pc;
   logic [31:0] exc_n, pc_n, addr_n;
   logic        ds_n;
   logic        unused_bits;

   always_comb begin
      fwd_status = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
      fwd_cause  = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i : cause_i;
      fwd_epc    = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
   end

   assign int_req = fwd_status[0] & ~fwd_status[1] & (|(fwd_status[15:8] & fwd_cause[15:8]));

   // Only the IE/EXL/IM/IP/IV fields matter here; the rest is folded away.
   assign unused_bits = ^{fwd_status[31:16], fwd_status[7:2],
                          fwd_cause[31:24], fwd_cause[22:16], fwd_cause[7:0]};

   always_comb begin
      code = '0;
      if (mem_valid_i) begin
         if (int_req)           code = 32'h1;
         else if (inst_inval_i) code = 32'ha;
         else if (syscall_i)    code = 32'h8;
         else if (trap_i)       code = 32'hd;
         else if (overflow_i)   code = 32'hc;
         else if (eret_i)       code = 32'he;
      end
   end

   always_comb begin
      if (code == 32'he)
         vec_pc = fwd_epc;
      else if (code == 32'h1 && fwd_cause[23])
         vec_pc = ebase_i + INT_OFFSET;
      else
         vec_pc = ebase_i + EXC_OFFSET;
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      exc_n       = excepttype_o;
      pc_n        = new_pc_o;
      addr_n      = current_inst_addr_o;
      ds_n        = is_in_delayslot_o;
      flush_o     = 1'b0;
      stall_req_o = 1'b0;
      case (state)
         IDLE: begin
            if (code != '0) begin
               state_n = FLUSH;
               exc_n   = code;
               pc_n    = vec_pc;
               addr_n  = mem_inst_addr_i;
               ds_n    = mem_in_delayslot_i;
            end
         end
         FLUSH: begin
            flush_o = 1'b1;
            exc_n   = '0;
            if (HOLD_CYCLES > 0) begin
               state_n = HOLD;
               cnt_n   = HOLD_LD;
            end else begin
               state_n = IDLE;
            end
         end
         HOLD: begin
            stall_req_o = 1'b1;
            if (cnt <= 3'd1) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         cnt                 <= '0;
         excepttype_o        <= '0;
         new_pc_o            <= '0;
         current_inst_addr_o <= '0;
         is_in_delayslot_o   <= 1'b0;
      end else begin
         state               <= state_n;
         cnt                 <= cnt_n;
         excepttype_o        <= exc_n;
         new_pc_o            <= pc_n;
         current_inst_addr_o <= addr_n;
         is_in_delayslot_o   <= ds_n;
      end
   end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: stall cycles after flush, range 0-7.
REQ-002 SHALL have parameter EXC_OFFSET, default 32'h180: general exception vector offset from EBase.
REQ-003 SHALL have parameter INT_OFFSET, default 32'h200: interrupt vector offset from EBase, used when Cause.IV=1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset. Ports: clk in 1, system clock; rst in 1, reset.
REQ-005 SHALL have these pipeline-side ports:
- mem_valid_i in 1: MEM-stage instruction valid.
- syscall_i, inst_inval_i, trap_i, overflow_i, eret_i in 1 each: MEM-stage event flags.
- mem_inst_addr_i in 32: MEM-stage PC.
- mem_in_delayslot_i in 1: MEM-stage instruction is in a delay slot.
REQ-006 SHALL have these CP0-side inputs:
- status_i, cause_i, epc_i, ebase_i in 32 each: CP0 register values.
- cp0_we_i in 1, cp0_waddr_i in 5, cp0_wdata_i in 32: pending writeback CP0 write.
REQ-007 SHALL have these outputs to CP0 and the pipeline:
- excepttype_o out 32.
- current_inst_addr_o out 32.
- is_in_delayslot_o out 1.
- flush_o out 1.
- new_pc_o out 32.
- stall_req_o out 1.

Function
REQ-008 SHALL forward register values: when cp0_we_i=1 and cp0_waddr_i is 12, 13 or 14, use cp0_wdata_i in place of status_i, cause_i or epc_i respectively.
REQ-009 SHALL compute int_req = fwd_status[0] & ~fwd_status[1] & |(fwd_status[15:8] & fwd_cause[15:8]).
REQ-010 SHALL qualify every event with mem_valid_i=1; a flag with mem_valid_i=0 is ignored.
REQ-011 SHALL prioritise events highest first:
- int_req -> 32'h1
- inst_inval -> 32'ha
- syscall -> 32'h8
- trap -> 32'hd
- overflow -> 32'hc
- eret -> 32'he
REQ-012 SHALL implement states IDLE, FLUSH and HOLD.
REQ-013 SHALL, in IDLE with a qualified event at edge T, register on that edge: excepttype_o = winning code, current_inst_addr_o = mem_inst_addr_i, is_in_delayslot_o = mem_in_delayslot_i, new_pc_o; then enter FLUSH.
REQ-014 SHALL select new_pc_o as follows:
- eret: fwd_epc.
- interrupt with fwd_cause[23]=1: ebase_i+INT_OFFSET.
- all others: ebase_i+EXC_OFFSET.
- All 32-bit adds wrap modulo 2^32.
REQ-015 SHALL, in FLUSH (exactly one cycle), drive flush_o=1 with excepttype_o, current_inst_addr_o, is_in_delayslot_o and new_pc_o stable.
REQ-016 SHALL, on leaving FLUSH, set excepttype_o=0 so that CP0 sees exactly one nonzero cycle per event.
REQ-017 SHALL leave FLUSH to HOLD when HOLD_CYCLES>0, otherwise to IDLE.
REQ-018 SHALL, in HOLD, drive stall_req_o=1 and flush_o=0, decrement a counter loaded with HOLD_CYCLES, and return to IDLE when it reaches 1.
REQ-019 SHALL ignore all events in FLUSH and HOLD; a level interrupt still asserted is taken on the first IDLE cycle.
REQ-020 SHALL NOT suppress syscall, inst_inval, trap or overflow when Status.EXL=1; the redirect still occurs (EPC preservation is CP0's duty).
REQ-021 SHALL hold new_pc_o, current_inst_addr_o and is_in_delayslot_o until the next event.
REQ-022 SHALL keep flush_o and stall_req_o at 0 in IDLE.

Reset
REQ-023 SHALL, while rst=0 (asynchronously), force state IDLE, counter 0, and all outputs 0.
REQ-024 SHALL, if reset asserts during FLUSH or HOLD, abort the sequence; the first post-reset cycle is IDLE with no flush.

Verification
REQ-025 SHALL cover syscall at PC 32'h80000100, EBase 32'h80000000 -> one flush_o cycle, excepttype 32'h8, new_pc 32'h80000180, stall_req_o=1 for 2 cycles.
REQ-026 SHALL cover overflow and interrupt in the same cycle, Status=32'h0000_0401, Cause[10]=1, IV=0 -> excepttype 32'h1, new_pc EBase+32'h180.
REQ-027 SHALL cover eret while writeback writes EPC=32'h80001234 -> new_pc 32'h80001234 (forwarded), excepttype 32'he.
REQ-028 SHALL cover trap in FLUSH followed by a second trap during HOLD -> second ignored, exactly one excepttype pulse.
REQ-029 SHALL cover rst=0 mid-HOLD -> flush_o, stall_req_o and excepttype_o go 0 immediately; IDLE after release.
REQ-030 SHALL cover HOLD_CYCLES=0 with an interrupt, IV=1 -> FLUSH then IDLE, no stall, new_pc EBase+32'h200.
